// File: rtl/can_tx_arbiter_if.sv
// Bundle of the requester side and the TX-buffer write port of can_tx_arbiter.
// The master modport is the environment (requesters plus CAN controller); slave is the arbiter.
interface can_tx_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned SRC_W = 2,
  parameter int unsigned GAP_W = 16
);
  logic                    enable;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [32*NREQ-1:0]      req_data;
  logic [GAP_W*NREQ-1:0]   req_gap;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_data;
  logic [SRC_W-1:0]        out_src;
  logic [15:0]             sent_cnt;

  modport master (
    output enable, req_valid, req_data, req_gap, out_ready,
    input  req_ready, out_valid, out_data, out_src, sent_cnt
  );

  modport slave (
    input  enable, req_valid, req_data, req_gap, out_ready,
    output req_ready, out_valid, out_data, out_src, sent_cnt
  );
endinterface

// File: rtl/can_tx_arbiter.sv
// Arbitrates NREQ word sources onto the single CAN TX-buffer write port.
// One word per grant; each source is rate-limited by its own inter-word gap counter.
module can_tx_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned SRC_W = 2,
  parameter int unsigned GAP_W = 16,
  parameter bit          RR    = 1'b1
) (
  input logic             clk,
  input logic             rst,
  can_tx_arbiter_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                      state_q, state_d;
  logic                        out_valid_q, out_valid_d;
  logic [31:0]                 out_data_q, out_data_d;
  logic [SRC_W-1:0]            out_src_q, out_src_d;
  logic [SRC_W-1:0]            ptr_q, ptr_d;
  logic [15:0]                 sent_cnt_q, sent_cnt_d;
  logic [NREQ-1:0][GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic [NREQ-1:0][31:0]       req_words;
  logic [NREQ-1:0][GAP_W-1:0]  req_gaps;
  logic [NREQ-1:0]             eligible;
  logic [NREQ-1:0]             req_ready;
  logic [SRC_W-1:0]            win_idx;
  logic [SRC_W:0]              idx;
  logic                        win_found;

  assign req_words = bus.req_data;
  assign req_gaps  = bus.req_gap;

  // A source may compete only when it has a word and its gap has expired.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = bus.req_valid[i] && (gap_cnt_q[i] == '0);
    end
  end

  // Winner search: first eligible index starting at the RR pointer (or at 0 for fixed priority).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = {1'b0, (RR ? ptr_q : '0)} + (SRC_W+1)'(k);
      if (idx >= (SRC_W+1)'(NREQ)) begin
        idx = idx - (SRC_W+1)'(NREQ);
      end
      if (!win_found && eligible[idx[SRC_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[SRC_W-1:0];
      end
    end
  end

  // Next-state, grant strobe and datapath updates.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    sent_cnt_d  = sent_cnt_q;
    req_ready   = '0;

    for (int unsigned i = 0; i < NREQ; i++) begin
      gap_cnt_d[i] = (gap_cnt_q[i] == '0) ? '0 : gap_cnt_q[i] - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // Grant is suppressed while reset is held so req_ready reads 0 during reset.
        if (!rst && bus.enable && win_found) begin
          req_ready[win_idx] = 1'b1;
          out_data_d         = req_words[win_idx];
          out_src_d          = win_idx;
          out_valid_d        = 1'b1;
          state_d            = StSend;
        end
      end
      StSend: begin
        if (bus.out_ready) begin
          out_valid_d          = 1'b0;
          sent_cnt_d           = sent_cnt_q + 16'd1;
          // Load wins over the decrement applied above.
          gap_cnt_d[out_src_q] = req_gaps[out_src_q];
          if (RR) begin
            ptr_d = (out_src_q == SRC_W'(NREQ - 1)) ? '0 : out_src_q + 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
      sent_cnt_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      sent_cnt_q  <= sent_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.sent_cnt  = sent_cnt_q;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Directed bench for can_tx_arbiter: a round-robin instance and a fixed-priority instance
// share the same stimulus. Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_can_tx_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned SRC_W = 2;
  localparam int unsigned GAP_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  can_tx_arbiter_if #(.NREQ(NREQ), .SRC_W(SRC_W), .GAP_W(GAP_W)) ifr ();
  can_tx_arbiter_if #(.NREQ(NREQ), .SRC_W(SRC_W), .GAP_W(GAP_W)) ifp ();

  assign ifp.enable    = ifr.enable;
  assign ifp.req_valid = ifr.req_valid;
  assign ifp.req_data  = ifr.req_data;
  assign ifp.req_gap   = ifr.req_gap;
  assign ifp.out_ready = ifr.out_ready;

  can_tx_arbiter #(.NREQ(NREQ), .SRC_W(SRC_W), .GAP_W(GAP_W), .RR(1'b1)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (ifr.slave)
  );

  can_tx_arbiter #(.NREQ(NREQ), .SRC_W(SRC_W), .GAP_W(GAP_W), .RR(1'b0)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (ifp.slave)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [31:0] d);
    ifr.req_data[32*i +: 32] = d;
  endtask

  task automatic set_gap(input int i, input logic [15:0] g);
    ifr.req_gap[GAP_W*i +: GAP_W] = g;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b1;
    ifr.enable    = 1'b0;
    ifr.req_valid = '0;
    ifr.req_data  = '0;
    ifr.req_gap   = '0;
    ifr.out_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (ifr.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b expected 0", ifr.out_valid); end
    checks++; if (ifr.out_data !== 32'h0) begin errors++;
      $display("FAIL reset_out_data: got %h expected 00000000", ifr.out_data); end
    checks++; if (ifr.out_src !== 2'd0) begin errors++;
      $display("FAIL reset_out_src: got %0d expected 0", ifr.out_src); end
    checks++; if (ifr.sent_cnt !== 16'h0) begin errors++;
      $display("FAIL reset_sent_cnt: got %h expected 0000", ifr.sent_cnt); end
    checks++; if (ifr.req_ready !== 4'b0000) begin errors++;
      $display("FAIL reset_req_ready: got %b expected 0000", ifr.req_ready); end
  endtask

  task automatic test_single();
    do_reset();
    ifr.enable    = 1'b1;
    ifr.out_ready = 1'b1;
    set_word(2, 32'hA5A5_0001);
    ifr.req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (ifr.req_ready !== 4'b0100) begin errors++;
      $display("FAIL single_req_ready: got %b expected 0100", ifr.req_ready); end
    next_cycle();
    ifr.req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (ifr.out_valid !== 1'b1) begin errors++;
      $display("FAIL single_out_valid: got %b expected 1", ifr.out_valid); end
    checks++; if (ifr.out_data !== 32'hA5A5_0001) begin errors++;
      $display("FAIL single_out_data: got %h expected a5a50001", ifr.out_data); end
    checks++; if (ifr.out_src !== 2'd2) begin errors++;
      $display("FAIL single_out_src: got %0d expected 2", ifr.out_src); end
    next_cycle();
    @(negedge clk);
    checks++; if (ifr.sent_cnt !== 16'd1) begin errors++;
      $display("FAIL single_sent_cnt: got %0d expected 1", ifr.sent_cnt); end
    checks++; if (ifr.out_valid !== 1'b0) begin errors++;
      $display("FAIL single_out_valid_drop: got %b expected 0", ifr.out_valid); end
  endtask

  task automatic test_round_robin();
    int          exp_src;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_word(i, 32'hC0DE_0000 + 32'(i));
    end
    ifr.enable    = 1'b1;
    ifr.out_ready = 1'b1;
    ifr.req_valid = 4'b1111;
    for (int w = 0; w < 8; w++) begin
      exp_src = w % 4;
      exp_d   = 32'hC0DE_0000 + 32'(exp_src);
      @(negedge clk);
      checks++; if (ifr.req_ready !== 4'(1 << exp_src)) begin errors++;
        $display("FAIL rr_req_ready word %0d: got %b expected %b", w, ifr.req_ready,
                 4'(1 << exp_src)); end
      checks++; if (ifp.req_ready !== 4'b0001) begin errors++;
        $display("FAIL fp_req_ready word %0d: got %b expected 0001", w, ifp.req_ready); end
      next_cycle();
      @(negedge clk);
      checks++; if (ifr.out_src !== 2'(exp_src)) begin errors++;
        $display("FAIL rr_out_src word %0d: got %0d expected %0d", w, ifr.out_src, exp_src); end
      checks++; if (ifr.out_data !== exp_d) begin errors++;
        $display("FAIL rr_out_data word %0d: got %h expected %h", w, ifr.out_data, exp_d); end
      checks++; if (ifp.out_src !== 2'd0) begin errors++;
        $display("FAIL fp_out_src word %0d: got %0d expected 0", w, ifp.out_src); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (ifr.sent_cnt !== 16'd8) begin errors++;
      $display("FAIL rr_sent_cnt: got %0d expected 8", ifr.sent_cnt); end
    ifr.req_valid = '0;
  endtask

  task automatic test_gap();
    int pulses[$];
    do_reset();
    set_word(1, 32'h0000_0011);
    set_gap(1, 16'd5);
    ifr.enable    = 1'b1;
    ifr.out_ready = 1'b1;
    ifr.req_valid = 4'b0010;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (ifr.req_ready[1] === 1'b1) pulses.push_back(c);
      next_cycle();
    end
    checks++; if (pulses.size() !== 4) begin errors++;
      $display("FAIL gap_pulse_count: got %0d expected 4", pulses.size()); end
    for (int p = 1; p < pulses.size(); p++) begin
      checks++; if (pulses[p] - pulses[p-1] !== 7) begin errors++;
        $display("FAIL gap_spacing %0d: got %0d expected 7", p, pulses[p] - pulses[p-1]); end
    end
    ifr.req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_word(i, 32'hBEEF_0000 + 32'(i));
    end
    ifr.enable    = 1'b1;
    ifr.out_ready = 1'b0;
    ifr.req_valid = 4'b0111;
    @(negedge clk);
    checks++; if (ifr.req_ready !== 4'b0001) begin errors++;
      $display("FAIL bp_first_grant: got %b expected 0001", ifr.req_ready); end
    next_cycle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({ifr.out_valid, ifr.out_data, ifr.req_ready} !== {1'b1, 32'hBEEF_0000, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got v=%b d=%h rdy=%b expected v=1 d=beef0000 rdy=0000",
                 c, ifr.out_valid, ifr.out_data, ifr.req_ready);
      end
      next_cycle();
    end
    ifr.out_ready = 1'b1;
    next_cycle();
    ifr.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (ifr.sent_cnt !== 16'd1) begin errors++;
      $display("FAIL bp_one_accept: got %0d expected 1", ifr.sent_cnt); end
    checks++; if (ifr.req_ready !== 4'b0010) begin errors++;
      $display("FAIL bp_next_grant: got %b expected 0010", ifr.req_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (ifr.out_src !== 2'd1) begin errors++;
      $display("FAIL bp_next_src: got %0d expected 1", ifr.out_src); end
    checks++; if (ifr.sent_cnt !== 16'd1) begin errors++;
      $display("FAIL bp_still_one: got %0d expected 1", ifr.sent_cnt); end
    ifr.req_valid = '0;
  endtask

  task automatic test_enable();
    do_reset();
    set_word(3, 32'h3333_3333);
    ifr.enable    = 1'b1;
    ifr.out_ready = 1'b0;
    ifr.req_valid = 4'b1000;
    @(negedge clk);
    checks++; if (ifr.req_ready !== 4'b1000) begin errors++;
      $display("FAIL en_grant: got %b expected 1000", ifr.req_ready); end
    next_cycle();
    ifr.enable    = 1'b0;
    ifr.out_ready = 1'b1;
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if ({ifr.out_valid, ifr.req_ready} !== 5'b0_0000) begin errors++;
        $display("FAIL en_blocked cycle %0d: got v=%b rdy=%b expected v=0 rdy=0000", c,
                 ifr.out_valid, ifr.req_ready); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (ifr.sent_cnt !== 16'd1) begin errors++;
      $display("FAIL en_word_completed: got %0d expected 1", ifr.sent_cnt); end
    next_cycle();
    ifr.enable = 1'b1;
    @(negedge clk);
    checks++; if (ifr.req_ready !== 4'b1000) begin errors++;
      $display("FAIL en_regrant: got %b expected 1000", ifr.req_ready); end
    next_cycle();
    ifr.req_valid = '0;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    // Preload the counter close to wrap instead of streaming 65535 words.
    force dut_rr.sent_cnt_q = 16'hFFFD;
    @(negedge clk);
    release dut_rr.sent_cnt_q;
    next_cycle();
    set_word(0, 32'h0F0F_0F0F);
    ifr.enable    = 1'b1;
    ifr.out_ready = 1'b1;
    ifr.req_valid = 4'b0001;
    next_cycle();
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (ifr.sent_cnt !== 16'hFFFF) begin errors++;
      $display("FAIL wrap_ffff: got %h expected ffff", ifr.sent_cnt); end
    next_cycle();
    next_cycle();
    ifr.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (ifr.sent_cnt !== 16'h0000) begin errors++;
      $display("FAIL wrap_zero: got %h expected 0000", ifr.sent_cnt); end
    next_cycle();
    @(negedge clk);
    checks++; if (ifr.out_valid !== 1'b1) begin errors++;
      $display("FAIL rst_pre_send: got %b expected 1", ifr.out_valid); end
    next_cycle();
    rst           = 1'b1;
    ifr.req_valid = '0;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({ifr.out_valid, ifr.out_data, ifr.out_src, ifr.sent_cnt, ifr.req_ready} !== '0) begin
      errors++;
      $display("FAIL rst_in_send: got v=%b d=%h src=%0d cnt=%h rdy=%b expected all 0",
               ifr.out_valid, ifr.out_data, ifr.out_src, ifr.sent_cnt, ifr.req_ready);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    ifr.enable    = 1'b0;
    ifr.req_valid = '0;
    ifr.req_data  = '0;
    ifr.req_gap   = '0;
    ifr.out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_gap();
    test_backpressure();
    test_enable();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
